// File: rtl/oled_pkg.sv
// Shared definitions for the PmodOLEDrgb serial path: transmitter states,
// default SCLK half-period and D/C pin encodings.
package oled_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } oled_state_t;

  localparam int OLED_HALF_CYCLES_DEFAULT = 8;

  localparam logic OLED_CMD  = 1'b0;
  localparam logic OLED_DATA = 1'b1;

endpackage

// File: rtl/sclk_phase_counter.sv
// Half-period timer for the SPI clock: counts 0..HALF_CYCLES-1 while run is
// high and flags the final cycle of each half-period.
module sclk_phase_counter #(
  parameter int HALF_CYCLES = 8
) (
  input  logic basys_clk,
  input  logic reset,
  input  logic run,
  output logic last
);

  // A one-bit counter is kept for HALF_CYCLES=1 so the width never collapses to zero.
  localparam int W = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [W-1:0] HC_MAX = W'(HALF_CYCLES - 1);

  logic [W-1:0] hc_q;
  logic [W-1:0] hc_d;

  always_comb begin
    hc_d = hc_q;
    if (!run || (hc_q == HC_MAX)) begin
      hc_d = '0;
    end else begin
      hc_d = hc_q + W'(1);
    end
  end

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      hc_q <= '0;
    end else begin
      hc_q <= hc_d;
    end
  end

  assign last = run && (hc_q == HC_MAX);

endmodule

// File: rtl/oled_spi_tx.sv
// Byte-wide SPI mode-0 transmitter for the SSD1331 OLED: valid/ready byte
// input, MSB-first shift-out with internally generated SCLK.
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int HALF_CYCLES = OLED_HALF_CYCLES_DEFAULT
) (
  input  logic       basys_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_dc
);

  oled_state_t state_q, state_d;
  logic [7:0]  sreg_q, sreg_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_ready_q, tx_ready_d;
  logic        tx_done_q, tx_done_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        dc_q, dc_d;
  logic        last;
  logic        accept;

  assign accept = tx_valid && tx_ready_q;

  sclk_phase_counter #(
    .HALF_CYCLES(HALF_CYCLES)
  ) u_phase (
    .basys_clk(basys_clk),
    .reset    (reset),
    .run      (state_q != IDLE),
    .last     (last)
  );

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      idx_q      <= '0;
      tx_ready_q <= 1'b0;
      tx_done_q  <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      dc_q       <= OLED_CMD;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      idx_q      <= idx_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q  <= tx_done_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      dc_q       <= dc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    dc_d    = dc_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          sreg_d  = tx_data;
          idx_d   = 3'd7;
          dc_d    = tx_dc;
        end
      end
      SETUP:    if (last) state_d = SHIFT_HI;
      SHIFT_HI: begin
        if (last) begin
          if (idx_q == 3'd0) begin
            state_d = HOLD;
          end else begin
            state_d = SHIFT_LO;
            idx_d   = idx_q - 3'd1;
          end
        end
      end
      SHIFT_LO: if (last) state_d = SHIFT_HI;
      HOLD:     if (last) state_d = GAP;
      GAP:      if (last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Pin values are decoded from the upcoming state so they switch on the same edge as the FSM.
  always_comb begin
    tx_ready_d = (state_d == IDLE);
    tx_done_d  = (state_d == GAP) && (state_q == HOLD);
    cs_n_d     = 1'b1;
    sclk_d     = (state_d == SHIFT_HI);
    mosi_d     = mosi_q;
    case (state_d)
      SETUP, SHIFT_HI, SHIFT_LO, HOLD: begin
        cs_n_d = 1'b0;
        mosi_d = sreg_d[idx_d];
      end
      default: ;
    endcase
  end

  assign tx_ready = tx_ready_q;
  assign tx_done  = tx_done_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_dc   = dc_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed bench for oled_spi_tx: one instance at HALF_CYCLES=8, one at
// HALF_CYCLES=1, with a pin monitor that timestamps every edge of interest.
module tb_oled_spi_tx;

  logic       basys_clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_dc = 1'b0;
  logic       tx_valid8 = 1'b0;
  logic       tx_valid1 = 1'b0;

  logic ready8, done8, cs_n8, sclk8, mosi8, dc8;
  logic ready1, done1, cs_n1, sclk1, mosi1, dc1;

  always #5 basys_clk = ~basys_clk;

  oled_spi_tx #(.HALF_CYCLES(8)) dut8 (
    .basys_clk(basys_clk), .reset(reset), .tx_data(tx_data), .tx_dc(tx_dc),
    .tx_valid(tx_valid8), .tx_ready(ready8), .tx_done(done8),
    .spi_cs_n(cs_n8), .spi_sclk(sclk8), .spi_mosi(mosi8), .spi_dc(dc8)
  );

  oled_spi_tx #(.HALF_CYCLES(1)) dut1 (
    .basys_clk(basys_clk), .reset(reset), .tx_data(tx_data), .tx_dc(tx_dc),
    .tx_valid(tx_valid1), .tx_ready(ready1), .tx_done(done1),
    .spi_cs_n(cs_n1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_dc(dc1)
  );

  logic sel = 1'b0;
  logic m_cs_n, m_sclk, m_mosi, m_done, m_ready;
  assign m_cs_n  = sel ? cs_n1  : cs_n8;
  assign m_sclk  = sel ? sclk1  : sclk8;
  assign m_mosi  = sel ? mosi1  : mosi8;
  assign m_done  = sel ? done1  : done8;
  assign m_ready = sel ? ready1 : ready8;

  int cyc = 0;
  int t0 = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge basys_clk) cyc <= cyc + 1;

  // Event times are the index of the edge at which the value is first sampled.
  int q_fall[$];
  int q_csrise[$];
  int q_rise[$];
  int q_done[$];
  int q_rdy[$];
  logic q_bit[$];
  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b0;
  logic prev_rdy = 1'b0;

  always @(negedge basys_clk) begin
    if (prev_cs && !m_cs_n) q_fall.push_back(cyc + 1);
    if (!prev_cs && m_cs_n) q_csrise.push_back(cyc + 1);
    if (!prev_sclk && m_sclk) begin
      q_rise.push_back(cyc + 1);
      q_bit.push_back(m_mosi);
    end
    if (m_done) q_done.push_back(cyc + 1);
    if (!prev_rdy && m_ready) q_rdy.push_back(cyc + 1);
    prev_cs   <= m_cs_n;
    prev_sclk <= m_sclk;
    prev_rdy  <= m_ready;
  end

  function automatic int ev_size(input int kind);
    case (kind)
      0: return q_fall.size();
      1: return q_csrise.size();
      2: return q_rise.size();
      3: return q_done.size();
      default: return q_rdy.size();
    endcase
  endfunction

  function automatic int ev_at(input int kind, input int i);
    case (kind)
      0: return q_fall[i];
      1: return q_csrise[i];
      2: return q_rise[i];
      3: return q_done[i];
      default: return q_rdy[i];
    endcase
  endfunction

  // kind: 0 cs fall, 1 cs rise, 2 sclk rise, 3 tx_done, 4 tx_ready rise.
  function automatic int rel_nth(input int kind, input int n);
    int k = 0;
    for (int i = 0; i < ev_size(kind); i++) begin
      if (ev_at(kind, i) > t0) begin
        if (k == n) return ev_at(kind, i) - t0;
        k++;
      end
    end
    return -1;
  endfunction

  function automatic int count_win(input int kind, input int lo, input int hi);
    int k = 0;
    for (int i = 0; i < ev_size(kind); i++) begin
      if ((ev_at(kind, i) - t0 >= lo) && (ev_at(kind, i) - t0 <= hi)) k++;
    end
    return k;
  endfunction

  function automatic logic [7:0] byte_at(input int n);
    logic [7:0] b = 8'h00;
    int k = 0;
    for (int i = 0; i < q_rise.size(); i++) begin
      if (q_rise[i] > t0) begin
        if (k >= n && k < n + 8) b = {b[6:0], q_bit[i]};
        k++;
      end
    end
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one byte at a negedge; t0 becomes the accepting edge index.
  task automatic applyStimulus(input logic s, input logic [7:0] d, input logic dc, input logic hold);
    @(negedge basys_clk);
    sel     = s;
    tx_data = d;
    tx_dc   = dc;
    if (s) tx_valid1 = 1'b1; else tx_valid8 = 1'b1;
    @(posedge basys_clk);
    @(negedge basys_clk);
    t0 = cyc;
    if (!hold) begin
      tx_valid1 = 1'b0;
      tx_valid8 = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge basys_clk);
    checkOutput("rst_cs_n", cs_n8, 1);
    checkOutput("rst_sclk", sclk8, 0);
    checkOutput("rst_mosi", mosi8, 0);
    checkOutput("rst_ready", ready8, 0);
    checkOutput("rst_dc", dc8, 0);
    reset = 1'b0;
    @(negedge basys_clk);
    checkOutput("ready_after_rst", ready8, 1);
    repeat (2) @(negedge basys_clk);

    applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0);
    repeat (150) @(negedge basys_clk);
    checkOutput("a5_cs_fall", rel_nth(0, 0), 1);
    checkOutput("a5_cs_low_len", rel_nth(1, 0) - rel_nth(0, 0), 136);
    checkOutput("a5_rise_cnt", count_win(2, 1, 150), 8);
    checkOutput("a5_rise_first", rel_nth(2, 0), 9);
    checkOutput("a5_rise_last", rel_nth(2, 7), 121);
    checkOutput("a5_bits", byte_at(0), 8'hA5);
    checkOutput("a5_done_cnt", count_win(3, 1, 150), 1);
    checkOutput("a5_done_t", rel_nth(3, 0), 137);
    checkOutput("a5_ready_t", rel_nth(4, 0), 145);
    checkOutput("a5_dc", dc8, 0);

    applyStimulus(1'b0, 8'h3C, 1'b1, 1'b1);
    tx_data = 8'hFF;
    repeat (145) @(negedge basys_clk);
    checkOutput("b2b_dc_mid", dc8, 1);
    tx_valid8 = 1'b0;
    repeat (150) @(negedge basys_clk);
    checkOutput("b2b_fall2", rel_nth(0, 1), 146);
    checkOutput("b2b_cs_high", rel_nth(0, 1) - rel_nth(1, 0), 9);
    checkOutput("b2b_byte1", byte_at(0), 8'h3C);
    checkOutput("b2b_byte2", byte_at(8), 8'hFF);
    checkOutput("b2b_rise9", rel_nth(2, 8), 154);
    checkOutput("b2b_done2", rel_nth(3, 1), 282);
    checkOutput("b2b_frames", count_win(0, 1, 295), 2);
    checkOutput("b2b_dc_end", dc8, 1);

    applyStimulus(1'b0, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 120; i++) begin
      @(negedge basys_clk);
      tx_data   = 8'($urandom);
      tx_dc     = 1'($urandom);
      tx_valid8 = 1'($urandom);
    end
    tx_valid8 = 1'b0;
    repeat (40) @(negedge basys_clk);
    checkOutput("noise_bits", byte_at(0), 8'h81);
    checkOutput("noise_frames", count_win(0, 1, 160), 1);
    checkOutput("noise_done", count_win(3, 1, 160), 1);
    checkOutput("noise_dc", dc8, 0);

    applyStimulus(1'b0, 8'h5A, 1'b1, 1'b0);
    repeat (49) @(negedge basys_clk);
    reset = 1'b1;
    @(negedge basys_clk);
    checkOutput("abort_cs_n", cs_n8, 1);
    checkOutput("abort_sclk", sclk8, 0);
    checkOutput("abort_dc", dc8, 0);
    reset = 1'b0;
    repeat (120) @(negedge basys_clk);
    checkOutput("abort_no_done", count_win(3, 1, 170), 0);

    applyStimulus(1'b0, 8'h12, 1'b0, 1'b0);
    repeat (150) @(negedge basys_clk);
    checkOutput("post_abort_bits", byte_at(0), 8'h12);
    checkOutput("post_abort_done", rel_nth(3, 0), 137);

    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    repeat (30) @(negedge basys_clk);
    checkOutput("h1_cs_fall", rel_nth(0, 0), 1);
    checkOutput("h1_cs_low_len", rel_nth(1, 0) - rel_nth(0, 0), 17);
    checkOutput("h1_rise_first", rel_nth(2, 0), 2);
    checkOutput("h1_rise_last", rel_nth(2, 7), 16);
    checkOutput("h1_rise_cnt", count_win(2, 1, 30), 8);
    checkOutput("h1_bits", byte_at(0), 8'h01);
    checkOutput("h1_done_t", rel_nth(3, 0), 18);
    checkOutput("h1_ready_t", rel_nth(4, 0), 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
